// File: rtl/line_clearer_if.sv
// Board-memory port plus control/status of the line clearer.
// Optional score output present when LINE_CLEARER_SCORE_EN is defined.
// master = the clearer itself, slave = placer/arbiter/memory side.
interface line_clearer_if;
  logic       start;
  logic [7:0] rdata;
  logic       we;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic       busy;
  logic       done;
  logic [4:0] lines_cleared;
`ifdef LINE_CLEARER_SCORE_EN
  logic [15:0] score;

  modport master (
    input  start, rdata,
    output we, addr, wdata, busy, done, lines_cleared, score
  );

  modport slave (
    output start, rdata,
    input  we, addr, wdata, busy, done, lines_cleared, score
  );
`else
  modport master (
    input  start, rdata,
    output we, addr, wdata, busy, done, lines_cleared
  );

  modport slave (
    output start, rdata,
    input  we, addr, wdata, busy, done, lines_cleared
  );
`endif
endinterface

// File: rtl/line_clearer.sv
// Purpose: after each placed piece, find full rows bottom-up and collapse them (shift rows above down, blank row 0).
// Latency: 2 cycles per cell read, 2 per shifted cell, 1 per blanked top cell, +1 DONE cycle; empty board = 41 cycles.
// Backpressure: none; start is ignored while busy. Macro LINE_CLEARER_SCORE_EN adds a saturating 16-bit score output.
module line_clearer #(
  parameter int COLS = 12,
  parameter int ROWS = 20
) (
  input logic            clk,
  input logic            rst,
  line_clearer_if.master bus
);

  typedef enum logic [2:0] {IDLE, RD, CHK, SH_RD, SH_WR, CLR, DONE} state_t;

  localparam logic [7:0] LAST_ROW = 8'(ROWS - 1);
  localparam logic [7:0] LAST_COL = 8'(COLS - 1);

  state_t     state;
  logic [7:0] row;
  logic [7:0] col;
  logic [7:0] dst;
  logic       we_q;
  logic [7:0] addr_q;
  logic       busy_q;
  logic       done_q;
  logic [4:0] lines_q;

  // Linear board address; ROWS*COLS fits in 8 bits so truncation is lossless.
  function automatic logic [7:0] cell_addr(input logic [7:0] r, input logic [7:0] c);
    return 8'(32'(r) * 32'(COLS) + 32'(c));
  endfunction

  // Scan / shift / clear sequencer; outputs are loaded for the state being entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      row     <= 8'd0;
      col     <= 8'd0;
      dst     <= 8'd0;
      we_q    <= 1'b0;
      addr_q  <= 8'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      lines_q <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          we_q   <= 1'b0;
          done_q <= 1'b0;
          if (bus.start) begin
            row     <= LAST_ROW;
            col     <= 8'd0;
            lines_q <= 5'd0;
            addr_q  <= cell_addr(LAST_ROW, 8'd0);
            busy_q  <= 1'b1;
            state   <= RD;
          end
        end
        RD: begin
          we_q  <= 1'b0;
          state <= CHK;
        end
        CHK: begin
          if (bus.rdata == 8'd0) begin
            if (row == 8'd0) begin
              done_q <= 1'b1;
              state  <= DONE;
            end else begin
              row    <= row - 8'd1;
              col    <= 8'd0;
              addr_q <= cell_addr(row - 8'd1, 8'd0);
              state  <= RD;
            end
          end else if (col < LAST_COL) begin
            col    <= col + 8'd1;
            addr_q <= cell_addr(row, col + 8'd1);
            state  <= RD;
          end else begin
            if (lines_q != 5'd31) lines_q <= lines_q + 5'd1;
            dst <= row;
            col <= 8'd0;
            if (row == 8'd0) begin
              we_q   <= 1'b1;
              addr_q <= 8'd0;
              state  <= CLR;
            end else begin
              addr_q <= cell_addr(row - 8'd1, 8'd0);
              state  <= SH_RD;
            end
          end
        end
        SH_RD: begin
          we_q   <= 1'b1;
          addr_q <= cell_addr(dst, col);
          state  <= SH_WR;
        end
        SH_WR: begin
          if (col < LAST_COL) begin
            col    <= col + 8'd1;
            we_q   <= 1'b0;
            addr_q <= cell_addr(dst - 8'd1, col + 8'd1);
            state  <= SH_RD;
          end else begin
            col <= 8'd0;
            dst <= dst - 8'd1;
            if (dst == 8'd1) begin
              we_q   <= 1'b1;
              addr_q <= 8'd0;
              state  <= CLR;
            end else begin
              we_q   <= 1'b0;
              addr_q <= cell_addr(dst - 8'd2, 8'd0);
              state  <= SH_RD;
            end
          end
        end
        CLR: begin
          if (col < LAST_COL) begin
            col    <= col + 8'd1;
            we_q   <= 1'b1;
            addr_q <= col + 8'd1;
          end else begin
            // Re-check the same row: it now holds what used to sit above it.
            col    <= 8'd0;
            we_q   <= 1'b0;
            addr_q <= cell_addr(row, 8'd0);
            state  <= RD;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          we_q   <= 1'b0;
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.we            = we_q;
  assign bus.addr          = addr_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.lines_cleared = lines_q;
  // The shifted byte only arrives during SH_WR, so write data is steered straight from the read port.
  assign bus.wdata         = (state == SH_WR) ? bus.rdata : 8'd0;

`ifdef LINE_CLEARER_SCORE_EN
  logic [15:0] score_q;
  logic [15:0] award;
  logic [16:0] score_sum;

  // Points awarded for the pass just finished.
  always_comb begin
    award = 16'd0;
    case (lines_q)
      5'd0:    award = 16'd0;
      5'd1:    award = 16'd40;
      5'd2:    award = 16'd100;
      5'd3:    award = 16'd300;
      default: award = 16'd1200;
    endcase
  end

  assign score_sum = {1'b0, score_q} + {1'b0, award};

  // Accumulate once per pass, clamped at full scale.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      score_q <= 16'd0;
    end else if (state == DONE) begin
      score_q <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
    end
  end

  assign bus.score = score_q;
`endif

endmodule

// File: tb/tb_line_clearer.sv
// Directed bench for line_clearer with a synchronous board-memory model.
// Covers reset values, empty board timing, single/quad/top-row clears, reset mid-shift, optional score.
module tb_line_clearer;
  localparam int COLS  = 12;
  localparam int ROWS  = 20;
  localparam int CELLS = COLS * ROWS;

  logic clk = 1'b0;
  logic rst;
  logic load_req;
  int   n_vec;
  int   n_miss;

  logic [7:0] mem [256];
  logic [7:0] img [256];
  logic [7:0] exp_img [256];

  always #5 clk = ~clk;

  line_clearer_if bus();

  line_clearer #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Board memory: one synchronous port, read data valid the cycle after addr.
  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < CELLS; i++) mem[i] <= img[i];
    end else if (bus.we) begin
      mem[bus.addr] <= bus.wdata;
    end
    bus.rdata <= mem[bus.addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  // Image with rows lo..hi filled with 8'h01, everything else empty.
  task automatic set_img(input int lo, input int hi);
    for (int i = 0; i < CELLS; i++) begin
      img[i]     = ((i / COLS) >= lo && (i / COLS) <= hi) ? 8'h01 : 8'h00;
      exp_img[i] = 8'h00;
    end
  endtask

  task automatic load_board();
    @(negedge clk);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  function automatic int board_diff();
    int bad = 0;
    for (int i = 0; i < CELLS; i++) if (mem[i] !== exp_img[i]) bad++;
    return bad;
  endfunction

  // One pass: pulse start, count cycles to done (1 = first cycle after the sampling edge),
  // we pulses, shift writes (we to rows below 0) and cycles with busy low.
  task automatic run_pass(input int extra_start_at, output int cyc, output int wes,
                          output int shifts, output int busy_lo);
    cyc = 0; wes = 0; shifts = 0; busy_lo = 0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int n = 1; n <= 5000; n++) begin
      if (bus.we) wes++;
      if (bus.we && bus.addr >= 8'(COLS)) shifts++;
      if (!bus.busy) busy_lo++;
      if (bus.done) begin
        cyc = n;
        break;
      end
      bus.start = (n == extra_start_at);
      @(negedge clk);
    end
    bus.start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc, wes, shifts, blo, hit;
    rst = 1'b0; bus.start = 1'b0; load_req = 1'b0;
    n_vec = 0; n_miss = 0;

    set_img(1, 0);
    load_board();
    @(negedge clk);
    check("rst_we", bus.we, 0);
    check("rst_addr", bus.addr, 0);
    check("rst_wdata", bus.wdata, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_lines", bus.lines_cleared, 0);
`ifdef LINE_CLEARER_SCORE_EN
    check("rst_score", bus.score, 0);
`endif
    rst = 1'b1;
    @(negedge clk);

    // Empty board; a stray start mid-pass must be ignored.
    run_pass(5, cyc, wes, shifts, blo);
    check("empty_cycles", cyc, 41);
    check("empty_we", wes, 0);
    check("empty_busy_low", blo, 0);
    check("empty_lines", bus.lines_cleared, 0);

    // Row 19 full, one block above it.
    set_img(19, 19);
    img[18*COLS+3] = 8'h05;
    exp_img[19*COLS+3] = 8'h05;
    load_board();
    run_pass(0, cyc, wes, shifts, blo);
    check("row19_cycles", cyc, 533);
    check("row19_we", wes, 240);
    check("row19_lines", bus.lines_cleared, 1);
    check("row19_cell", mem[19*COLS+3], 8'h05);
    check("row19_board", board_diff(), 0);

    // Four bottom rows full.
    set_img(16, 19);
    load_board();
    run_pass(0, cyc, wes, shifts, blo);
    check("quad_cycles", cyc, 2009);
    check("quad_we", wes, 960);
    check("quad_lines", bus.lines_cleared, 4);
    check("quad_board", board_diff(), 0);

    // Top row only: blanked directly, nothing shifted.
    set_img(0, 0);
    load_board();
    run_pass(0, cyc, wes, shifts, blo);
    check("top_cycles", cyc, 77);
    check("top_shifts", shifts, 0);
    check("top_we", wes, 12);
    check("top_lines", bus.lines_cleared, 1);
    check("top_board", board_diff(), 0);

    // Reset during the first shift write, then a normal pass on the untouched board.
    set_img(19, 19);
    img[18*COLS+3] = 8'h05;
    exp_img[19*COLS+3] = 8'h05;
    load_board();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    hit = 0;
    for (int n = 1; n <= 200; n++) begin
      if (bus.we && bus.addr >= 8'(COLS)) begin
        hit = n;
        break;
      end
      @(negedge clk);
    end
    check("mid_shwr_cycle", hit, 26);
    check("mid_shwr_addr", bus.addr, 228);
    rst = 1'b0;
    #1;
    check("mid_rst_we", bus.we, 0);
    check("mid_rst_addr", bus.addr, 0);
    check("mid_rst_wdata", bus.wdata, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_done", bus.done, 0);
    check("mid_rst_lines", bus.lines_cleared, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_pass(0, cyc, wes, shifts, blo);
    check("after_rst_cycles", cyc, 533);
    check("after_rst_lines", bus.lines_cleared, 1);
    check("after_rst_cell", mem[19*COLS+3], 8'h05);

`ifdef LINE_CLEARER_SCORE_EN
    // Fresh score: a 2-line pass then a 4-line pass.
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("score_rst", bus.score, 0);
    rst = 1'b1;
    set_img(18, 19);
    load_board();
    run_pass(0, cyc, wes, shifts, blo);
    check("score_two_lines", bus.lines_cleared, 2);
    @(negedge clk);
    check("score_after_two", bus.score, 100);
    set_img(16, 19);
    load_board();
    run_pass(0, cyc, wes, shifts, blo);
    @(negedge clk);
    check("score_after_four", bus.score, 1300);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
